// File: rtl/fwd_pkg.sv
// Shared types for the Execute-stage forwarding and load-use hazard logic.
// Pulled in by fwd_hazard_unit and fwd_operand_mux.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // Control snapshot for the hazard FSM; outputs are taken from it so checkers can bind here.
  typedef struct packed {
    hz_state_t state;
    logic      hz;
    logic      stall;
    logic      flush_d;
    logic      flush_e;
  } hz_dbg_t;

  localparam int REG_ZERO = 0;

  // Memory-stage result is younger than Writeback, so it wins.
  function automatic fwd_sel_t pick_sel(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_MEM;
    if (hit_w) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// One Execute operand: select between register-file value, Writeback and Memory results.
// An unused select code falls back to the register value.
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] reg_val,
  input  logic [WIDTH-1:0] wb_val,
  input  logic [WIDTH-1:0] mem_val,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (fwd_sel_t'(sel))
      FWD_MEM: y = mem_val;
      FWD_WB:  y = wb_val;
      default: y = reg_val;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding for NUM_SRC Execute operands plus load-use stall and branch-flush control.
// Define FWD_HAZARD_PERF_EN to add saturating stall/flush event counters on perf_* ports.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*REG_AW-1:0]  rs_d,
  input  logic [NUM_SRC*REG_AW-1:0]  rs_e,
  input  logic [REG_AW-1:0]          rd_e,
  input  logic                       load_e,
  input  logic [REG_AW-1:0]          rd_m,
  input  logic                       regwrite_m,
  input  logic [REG_AW-1:0]          rd_w,
  input  logic                       regwrite_w,
  input  logic                       pcsrc_e,
  input  logic [NUM_SRC*WIDTH-1:0]   rd_e_data,
  input  logic [WIDTH-1:0]           aluresult_m,
  input  logic [WIDTH-1:0]           result_w,
  output logic [NUM_SRC*2-1:0]       fwd_sel,
  output logic [NUM_SRC*WIDTH-1:0]   src_e,
  output logic                       stall_f,
  output logic                       stall_d,
  output logic                       flush_d,
  output logic                       flush_e
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_flush_cnt
`endif
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  hz_state_t     state;
  logic [CW-1:0] cnt;
  logic          hz_match;
  logic          hz;
  hz_dbg_t       dbg;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic              hit_m;
    logic              hit_w;
    fwd_sel_t          sel;

    assign rs    = rs_e[i*REG_AW +: REG_AW];
    assign hit_m = regwrite_m && (rd_m == rs) && (rd_m != RZ);
    assign hit_w = regwrite_w && (rd_w == rs) && (rd_w != RZ);
    assign sel   = rst ? FWD_REG : pick_sel(hit_m, hit_w);
    assign fwd_sel[2*i +: 2] = sel;

    fwd_operand_mux #(.WIDTH(WIDTH)) u_mux (
      .sel     (sel),
      .reg_val (rd_e_data[i*WIDTH +: WIDTH]),
      .wb_val  (result_w),
      .mem_val (aluresult_m),
      .y       (src_e[i*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    hz_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_d[i*REG_AW +: REG_AW] == rd_e) hz_match = 1'b1;
    end
  end

  assign hz = load_e && (rd_e != RZ) && hz_match;

  // Reset and a taken branch both override any stall request.
  always_comb begin
    dbg.state   = state;
    dbg.hz      = hz;
    dbg.stall   = 1'b0;
    dbg.flush_d = 1'b0;
    dbg.flush_e = 1'b0;
    if (rst || pcsrc_e) begin
      dbg.flush_d = 1'b1;
      dbg.flush_e = 1'b1;
    end else if ((dbg.state == STALL) || dbg.hz) begin
      dbg.stall   = 1'b1;
      dbg.flush_e = 1'b1;
    end
  end

  assign stall_f = dbg.stall;
  assign stall_d = dbg.stall;
  assign flush_d = dbg.flush_d;
  assign flush_e = dbg.flush_e;

  // The first bubble is issued from IDLE; cnt covers the remaining LOAD_LAT-1.
  always_ff @(posedge clk) begin
    if (rst || pcsrc_e) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hz && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= CW'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          if (cnt <= CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_d && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pcsrc_e && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (LOAD_LAT 1, 2, 3) share one stimulus stream
// and are compared every cycle against a bubble-count reference model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_d, rs_e;
  logic [4:0]  rd_e, rd_m, rd_w;
  logic        load_e, regwrite_m, regwrite_w, pcsrc_e;
  logic [63:0] rd_e_data;
  logic [31:0] aluresult_m, result_w;

  logic [3:0]  fwd_sel_o [3];
  logic [63:0] src_e_o   [3];
  logic        stall_f_o [3];
  logic        stall_d_o [3];
  logic        flush_d_o [3];
  logic        flush_e_o [3];
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] pst_o [3];
  logic [31:0] pfl_o [3];
  longint      pst_m [3];
  longint      pfl_m [3];
`endif

  int checks = 0;
  int errors = 0;
  int rem [3];
  logic [63:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fwd_hazard_unit #(.WIDTH(32), .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(g + 1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .rs_d        (rs_d),
      .rs_e        (rs_e),
      .rd_e        (rd_e),
      .load_e      (load_e),
      .rd_m        (rd_m),
      .regwrite_m  (regwrite_m),
      .rd_w        (rd_w),
      .regwrite_w  (regwrite_w),
      .pcsrc_e     (pcsrc_e),
      .rd_e_data   (rd_e_data),
      .aluresult_m (aluresult_m),
      .result_w    (result_w),
      .fwd_sel     (fwd_sel_o[g]),
      .src_e       (src_e_o[g]),
      .stall_f     (stall_f_o[g]),
      .stall_d     (stall_d_o[g]),
      .flush_d     (flush_d_o[g]),
      .flush_e     (flush_e_o[g])
`ifdef FWD_HAZARD_PERF_EN
      ,
      .perf_stall_cnt (pst_o[g]),
      .perf_flush_cnt (pfl_o[g])
`endif
    );
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst = 1'b0; rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    load_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0; pcsrc_e = 1'b0;
    rd_e_data = {32'h1111_0001, 32'h2222_0002};
    aluresult_m = 32'hAAAA; result_w = 32'hBBBB;
  endtask

  task automatic settle();
    #3;
  endtask

  // Reference model: forwarding from the priority rules, stalls from a remaining-bubble count.
  task automatic model_step();
    logic [3:0]  esel;
    logic [63:0] esrc;
    logic        hzm, est, efd, efe;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] r;
      r = rs_e[i*5 +: 5];
      if (!rst && regwrite_m && rd_m == r && rd_m != 5'd0) begin
        esel[i*2 +: 2] = 2'b10; esrc[i*32 +: 32] = aluresult_m;
      end else if (!rst && regwrite_w && rd_w == r && rd_w != 5'd0) begin
        esel[i*2 +: 2] = 2'b01; esrc[i*32 +: 32] = result_w;
      end else begin
        esel[i*2 +: 2] = 2'b00; esrc[i*32 +: 32] = rd_e_data[i*32 +: 32];
      end
    end
    hzm = load_e && (rd_e != 5'd0) && (rs_d[4:0] == rd_e || rs_d[9:5] == rd_e);
    for (int k = 0; k < 3; k++) begin
      lat = k + 1;
      est = 1'b0; efd = 1'b0; efe = 1'b0;
      if (rst || pcsrc_e) begin
        efd = 1'b1; efe = 1'b1;
      end else if (rem[k] > 0 || hzm) begin
        est = 1'b1; efe = 1'b1;
      end
      check_eq($sformatf("fwd_sel L%0d", lat), 64'(fwd_sel_o[k]), 64'(esel));
      check_eq($sformatf("src_e L%0d", lat), src_e_o[k], esrc);
      check_eq($sformatf("stall_f L%0d", lat), 64'(stall_f_o[k]), 64'(est));
      check_eq($sformatf("stall_d L%0d", lat), 64'(stall_d_o[k]), 64'(est));
      check_eq($sformatf("flush_d L%0d", lat), 64'(flush_d_o[k]), 64'(efd));
      check_eq($sformatf("flush_e L%0d", lat), 64'(flush_e_o[k]), 64'(efe));
`ifdef FWD_HAZARD_PERF_EN
      check_eq($sformatf("perf_stall L%0d", lat), 64'(pst_o[k]), 64'(pst_m[k]));
      check_eq($sformatf("perf_flush L%0d", lat), 64'(pfl_o[k]), 64'(pfl_m[k]));
      if (rst) begin
        pst_m[k] = 0; pfl_m[k] = 0;
      end else begin
        pst_m[k] += longint'(est);
        pfl_m[k] += longint'(pcsrc_e);
      end
`endif
      if (rst || pcsrc_e)  rem[k] = 0;
      else if (rem[k] > 0) rem[k] = rem[k] - 1;
      else if (hzm)        rem[k] = lat - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    model_step();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n [3];
    for (int k = 0; k < 3; k++) rem[k] = 0;
`ifdef FWD_HAZARD_PERF_EN
    for (int k = 0; k < 3; k++) begin pst_m[k] = 0; pfl_m[k] = 0; end
`endif
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    settle();
    check_eq("rst flush_d", 64'(flush_d_o[0]), 64'd1);
    check_eq("rst stall_d", 64'(stall_d_o[0]), 64'd0);
    model_step();
    rst = 1'b0;
    step();

    // forwarding priority: Memory over Writeback
    rs_e = {5'd0, 5'd5}; rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1;
    settle();
    check_eq("prio sel0 mem", 64'(fwd_sel_o[0][1:0]), 64'(2'b10));
    check_eq("prio src0 mem", 64'(src_e_o[0][31:0]), 64'h0000_AAAA);
    model_step();
    regwrite_m = 1'b0;
    settle();
    check_eq("prio sel0 wb", 64'(fwd_sel_o[0][1:0]), 64'(2'b01));
    check_eq("prio src0 wb", 64'(src_e_o[0][31:0]), 64'h0000_BBBB);
    model_step();

    // x0 never forwarded
    rs_e = {5'd0, 5'd9}; rd_m = 5'd0; regwrite_m = 1'b1; regwrite_w = 1'b0;
    settle();
    check_eq("x0 sel1", 64'(fwd_sel_o[0][3:2]), 64'd0);
    check_eq("x0 src1", 64'(src_e_o[0][63:32]), 64'h1111_0001);
    model_step();

    // load-use bubble count for each LOAD_LAT
    do_reset();
    for (int k = 0; k < 3; k++) begin n[k] = 0; exp_q.push_back(64'(k + 1)); end
    load_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd3};
    for (int c = 0; c < 6; c++) begin
      settle();
      for (int k = 0; k < 3; k++) if (stall_d_o[k]) n[k]++;
      model_step();
      load_e = 1'b0;
    end
    for (int k = 0; k < 3; k++) check_eq($sformatf("bubbles L%0d", k + 1), 64'(n[k]), exp_q.pop_front());

    // branch in the 2nd stall cycle of LOAD_LAT=3
    do_reset();
    load_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
    step();
    load_e = 1'b0; pcsrc_e = 1'b1;
    settle();
    check_eq("br stall_d", 64'(stall_d_o[2]), 64'd0);
    check_eq("br flush_d", 64'(flush_d_o[2]), 64'd1);
    check_eq("br flush_e", 64'(flush_e_o[2]), 64'd1);
    model_step();
    pcsrc_e = 1'b0;
    settle();
    check_eq("br after stall_d", 64'(stall_d_o[2]), 64'd0);
    model_step();

    // reset in the 2nd stall cycle of LOAD_LAT=3
    do_reset();
    load_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
    step();
    load_e = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check_eq("rst mid stall_d", 64'(stall_d_o[2]), 64'd0);
    model_step();

`ifdef FWD_HAZARD_PERF_EN
    // two hazards at LOAD_LAT=2 plus one branch
    do_reset();
    for (int h = 0; h < 2; h++) begin
      load_e = 1'b1; rd_e = 5'd4; rs_d = {5'd0, 5'd4};
      step();
      load_e = 1'b0;
      step();
      step();
    end
    pcsrc_e = 1'b1;
    step();
    pcsrc_e = 1'b0;
    settle();
    check_eq("perf stall L2", 64'(pst_o[1]), 64'd4);
    check_eq("perf flush L2", 64'(pfl_o[1]), 64'd1);
    model_step();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      rst         = ($urandom_range(0, 49) == 0);
      pcsrc_e     = ($urandom_range(0, 7) == 0);
      load_e      = ($urandom_range(0, 2) == 0);
      rd_e        = 5'($urandom_range(0, 3));
      rs_d        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_e        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rd_m        = 5'($urandom_range(0, 3));
      rd_w        = 5'($urandom_range(0, 3));
      regwrite_m  = 1'($urandom_range(0, 1));
      regwrite_w  = 1'($urandom_range(0, 1));
      rd_e_data   = {$urandom, $urandom};
      aluresult_m = $urandom;
      result_w    = $urandom;
      step();
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Next-generation forwarding and hazard block for the 5-stage RV32I pipeline.
- Replaces the per-operand forwarding muxes with a single parametrised unit covering NUM_SRC Execute-stage operands.
- Computes forward selects, applies them, and owns load-use stall sequencing (configurable bubble count) plus branch flush.
- Sits between the Decode/Execute pipeline registers and the ALU input.

Parameters:
- WIDTH, 32, datapath width.
- REG_AW, 5, register-address width.
- NUM_SRC, 2, number of Execute operands forwarded (rs1, rs2, ...).
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1 = classic; >1 for a multi-cycle memory stage); must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rs_d  in  NUM_SRC*REG_AW  source registers of the instruction in Decode.
- rs_e  in  NUM_SRC*REG_AW  source registers of the instruction in Execute.
- rd_e  in  REG_AW  destination register in Execute.
- load_e  in  1  Execute instruction is a load (ResultSrcE selects memory).
- rd_m  in  REG_AW  destination register in Memory.
- regwrite_m  in  1  Memory-stage register write enable.
- rd_w  in  REG_AW  destination register in Writeback.
- regwrite_w  in  1  Writeback-stage register write enable.
- pcsrc_e  in  1  taken branch/jump resolved in Execute.
- rd_e_data  in  NUM_SRC*WIDTH  register-file operands latched in Execute.
- aluresult_m  in  WIDTH  ALU result in Memory.
- result_w  in  WIDTH  Writeback result (WD3).
- fwd_sel  out  NUM_SRC*2  per-operand select: 00 register, 01 Writeback, 10 Memory.
- src_e  out  NUM_SRC*WIDTH  forwarded operands.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the Fetch/Decode register.
- flush_d  out  1  clear the Fetch/Decode register.
- flush_e  out  1  clear the Decode/Execute register.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Forwarding is combinational, zero latency, per operand i:
  - sel = 10 if regwrite_m and rd_m == rs_e[i] and rd_m != 0.
  - else sel = 01 if regwrite_w and rd_w == rs_e[i] and rd_w != 0.
  - else sel = 00.
  - Memory has priority over Writeback. x0 is never forwarded. Code 11 is never generated; src_e defaults to the register value if it ever appears.
- Load-use detect (hz) = load_e and rd_e != 0 and rd_e matches any rs_d[i].
- FSM states: IDLE and STALL; down-counter cnt of width clog2(LOAD_LAT+1).
  - IDLE, hz=1: stall_f = stall_d = flush_e = 1 in the same cycle. If LOAD_LAT > 1, go to STALL with cnt = LOAD_LAT-1; otherwise stay in IDLE.
  - STALL: stall_f = stall_d = flush_e = 1; cnt decrements each cycle. When cnt reaches 1 → IDLE. The hz input is ignored while in STALL.
- Branch flush: pcsrc_e → flush_d = flush_e = 1.
  - If pcsrc_e and hz coincide, or pcsrc_e arrives during STALL: the flush wins, stall_f = stall_d = 0, and the FSM goes to IDLE with cnt = 0.
- Reset:
  - rst high: FSM → IDLE, cnt → 0.
  - While rst is high: stall_f = stall_d = 0, flush_d = flush_e = 1, fwd_sel = 0, src_e = rd_e_data.
  - Reset in the middle of a stall aborts it with no residual stall cycles.
- Total bubbles per hazard: exactly LOAD_LAT cycles.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds two 32-bit saturating counters, cleared by rst.
  - stall_cnt: +1 each cycle stall_d = 1.
  - flush_cnt: +1 each cycle pcsrc_e = 1.
  - Exposed on output ports perf_stall_cnt and perf_flush_cnt.
- Undefined: no counters and no perf ports; all other behaviour identical.

Decomposition:
- Shared package fwd_pkg:
  - typedef fwd_sel_t (enum FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10).
  - typedef hz_state_t (enum IDLE, STALL).
  - Constant REG_ZERO.
- One natural sub-module, fwd_operand_mux: a WIDTH-parametrised 3-input select on fwd_sel_t, instantiated NUM_SRC times by generate.

Test Plan:
- Forwarding priority: rs_e[0] = 5, rd_m = 5 with regwrite_m, rd_w = 5 with regwrite_w, aluresult_m = 0xAAAA, result_w = 0xBBBB → fwd_sel[0] = 10, src_e[0] = 0xAAAA. Drop regwrite_m → 01, src_e[0] = 0xBBBB.
- x0 guard: rs_e[1] = 0, rd_m = 0, regwrite_m = 1 → fwd_sel[1] = 00, src_e[1] = rd_e_data[1].
- Load-use bubble, LOAD_LAT = 1: load_e = 1, rd_e = 7, rs_d[1] = 7 → stall_f = stall_d = flush_e = 1 for exactly 1 cycle. With LOAD_LAT = 3 → exactly 3 cycles.
- Branch during stall: LOAD_LAT = 3, pcsrc_e pulsed in the 2nd stall cycle → that cycle flush_d = flush_e = 1 and stall_d = 0; the next cycle has no stall.
- Reset mid-stall: rst in the 2nd of 3 stall cycles → the next cycle is IDLE, stall_d = 0.
- Perf (macro defined): 2 hazards with LOAD_LAT = 2 plus 1 branch → perf_stall_cnt = 4, perf_flush_cnt = 1.
